// File: rtl/pc_unit.sv
// Fetch-stage program counter: write > stall > ret > call > branch > step.
// Optional return-address stack is built when PC_RAS_EN is defined.
module pc_unit #(
  parameter int unsigned     WIDTH     = 32,
  parameter int unsigned     STEP      = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             we,
  input  logic [WIDTH-1:0] wd,
  input  logic             ib,
  input  logic [WIDTH-1:0] bv,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] iaddrout,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ret_miss
);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_pc_d;
  logic [WIDTH-1:0] w_pc_step;
  logic [WIDTH-1:0] w_pc_rel;

  assign w_pc_step = r_pc + WIDTH'(STEP);
  assign w_pc_rel  = r_pc + bv;
  assign iaddrout  = r_pc;

`ifdef PC_RAS_EN
  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] r_mem [RAS_DEPTH];
  logic [PtrW-1:0]  r_wp, w_wp_d;
  logic [CntW-1:0]  r_cnt, w_cnt_d;
  logic             r_empty, r_full, r_ret_miss;
  logic             w_push, w_miss;
  logic [PtrW-1:0]  w_top;

  // r_wp points at the next free slot; when full it also points at the oldest entry.
  assign w_top = r_wp - PtrW'(1);

  always_comb begin
    w_pc_d  = r_pc;
    w_wp_d  = r_wp;
    w_cnt_d = r_cnt;
    w_push  = 1'b0;
    w_miss  = 1'b0;
    if (we) begin
      w_pc_d = wd;
    end else if (!stall) begin
      if (ret) begin
        if (r_cnt != '0) begin
          w_pc_d  = r_mem[w_top];
          w_wp_d  = w_top;
          w_cnt_d = r_cnt - CntW'(1);
        end else begin
          w_pc_d = w_pc_step;
          w_miss = 1'b1;
        end
      end else if (call) begin
        w_push = 1'b1;
        w_pc_d = w_pc_rel;
        w_wp_d = r_wp + PtrW'(1);
        if (r_cnt != CntW'(RAS_DEPTH)) begin
          w_cnt_d = r_cnt + CntW'(1);
        end
      end else if (ib) begin
        w_pc_d = w_pc_rel;
      end else begin
        w_pc_d = w_pc_step;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc       <= RESET_VEC;
      r_wp       <= '0;
      r_cnt      <= '0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
      r_ret_miss <= 1'b0;
    end else begin
      r_pc       <= w_pc_d;
      r_wp       <= w_wp_d;
      r_cnt      <= w_cnt_d;
      r_empty    <= (w_cnt_d == '0);
      r_full     <= (w_cnt_d == CntW'(RAS_DEPTH));
      r_ret_miss <= w_miss;
    end
  end

  // Entries are not reset; a push during reset is discarded.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_mem[r_wp] <= w_pc_step;
    end
  end

  assign ras_empty = r_empty;
  assign ras_full  = r_full;
  assign ret_miss  = r_ret_miss;
`else
  logic w_unused_cfg;

  assign w_unused_cfg = (RAS_DEPTH != 0);

  // Without a stack, call degrades to a branch and ret to a plain step.
  always_comb begin
    w_pc_d = r_pc;
    if (we) begin
      w_pc_d = wd;
    end else if (!stall) begin
      if (ret) begin
        w_pc_d = w_pc_step;
      end else if (call || ib) begin
        w_pc_d = w_pc_rel;
      end else begin
        w_pc_d = w_pc_step;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc <= RESET_VEC;
    end else begin
      r_pc <= w_pc_d;
    end
  end

  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
  assign ret_miss  = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios then random traffic against a
// queue-based model of the PC and return stack.
module tb_pc_unit;

  localparam int unsigned W     = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [W-1:0] RV   = 32'h100;

  logic         clk = 1'b0;
  logic         rst_n, stall, we, ib, call, ret;
  logic [W-1:0] wd, bv;
  logic [W-1:0] iaddrout;
  logic         ras_empty, ras_full, ret_miss;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  logic [W-1:0] m_pc;
  logic [W-1:0] m_ras[$];
  logic         m_miss;

  pc_unit #(
    .WIDTH     (W),
    .STEP      (4),
    .RESET_VEC (RV),
    .RAS_DEPTH (DEPTH)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .we        (we),
    .wd        (wd),
    .ib        (ib),
    .bv        (bv),
    .call      (call),
    .ret       (ret),
    .iaddrout  (iaddrout),
    .ras_empty (ras_empty),
    .ras_full  (ras_full),
    .ret_miss  (ret_miss)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    m_miss = 1'b0;
    if (!rst_n) begin
      m_pc = RV;
      m_ras.delete();
    end else if (we) begin
      m_pc = wd;
    end else if (stall) begin
      m_pc = m_pc;
    end else if (ret) begin
`ifdef PC_RAS_EN
      if (m_ras.size() > 0) begin
        m_pc = m_ras.pop_back();
      end else begin
        m_pc   = m_pc + 4;
        m_miss = 1'b1;
      end
`else
      m_pc = m_pc + 4;
`endif
    end else if (call) begin
`ifdef PC_RAS_EN
      if (m_ras.size() == DEPTH) void'(m_ras.pop_front());
      m_ras.push_back(m_pc + 4);
`endif
      m_pc = m_pc + bv;
    end else if (ib) begin
      m_pc = m_pc + bv;
    end else begin
      m_pc = m_pc + 4;
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic w, input logic [W-1:0] d,
                       input logic b, input logic [W-1:0] v, input logic c, input logic t);
    rst_n = r; stall = s; we = w; wd = d; ib = b; bv = v; call = c; ret = t;
  endtask

  // One clock: model consumes the inputs seen at the edge, outputs sampled 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check("pc", iaddrout, m_pc);
    check("empty", W'(ras_empty), W'(m_ras.size() == 0));
    check("full", W'(ras_full), W'(m_ras.size() == DEPTH));
    check("miss", W'(ret_miss), W'(m_miss));
  endtask

  task automatic idle();
    drive(1, 0, 0, '0, 0, '0, 0, 0);
    cyc();
  endtask

  task automatic load(input logic [W-1:0] a);
    drive(1, 0, 1, a, 0, '0, 0, 0);
    cyc();
  endtask

  initial begin
    m_pc   = '0;
    m_miss = 1'b0;
    drive(0, 0, 0, '0, 0, '0, 0, 0);
    #2;
    cyc();
    check("reset_pc", iaddrout, 32'h100);
    check("reset_empty", W'(ras_empty), 32'h1);
    idle(); check("step1", iaddrout, 32'h104);
    idle(); check("step2", iaddrout, 32'h108);
    idle(); check("step3", iaddrout, 32'h10C);

    // Priority: we beats stall and ib; stall holds; negative branch
    load(32'h200);
    drive(1, 1, 1, 32'h40, 1, 32'h10, 0, 0); cyc(); check("we_over_stall", iaddrout, 32'h40);
    drive(1, 1, 0, '0, 0, '0, 0, 0);         cyc(); check("stall_hold", iaddrout, 32'h40);
    drive(1, 0, 0, '0, 1, 32'hFFFF_FFF0, 0, 0); cyc(); check("neg_branch", iaddrout, 32'h30);

    // Wrap
    load(32'hFFFF_FFFC);
    idle(); check("wrap", iaddrout, 32'h0);

`ifdef PC_RAS_EN
    load(32'h1000);
    drive(1, 0, 0, '0, 0, 32'h80, 1, 0); cyc();
    check("call_pc", iaddrout, 32'h1080);
    check("call_nonempty", W'(ras_empty), 32'h0);
    idle(); idle();
    drive(1, 0, 0, '0, 0, '0, 0, 1); cyc();
    check("ret_pc", iaddrout, 32'h1004);
    check("ret_empty", W'(ras_empty), 32'h1);

    // Five nested calls overflow a 4-deep stack
    load(32'h0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, '0, 0, 32'h100, 1, 0); cyc();
      if (i == 3) check("full_after4", W'(ras_full), 32'h1);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, '0, 0, '0, 0, 1); cyc();
      check("ovf_ret", iaddrout, 32'h404 - 32'(i) * 32'h100);
    end
    drive(1, 0, 0, '0, 0, '0, 0, 1); cyc();
    check("ret_miss_pc", iaddrout, 32'h108);
    check("ret_miss", W'(ret_miss), 32'h1);
    idle(); check("ret_miss_pulse", W'(ret_miss), 32'h0);

    // call and ret together with empty stack
    load(32'h4);
    drive(1, 0, 0, '0, 0, 32'h40, 1, 1); cyc();
    check("callret_pc", iaddrout, 32'h8);
    check("callret_miss", W'(ret_miss), 32'h1);
    check("callret_nopush", W'(ras_empty), 32'h1);
`else
    load(32'h0);
    drive(1, 0, 0, '0, 0, 32'h20, 1, 0); cyc(); check("call_as_branch", iaddrout, 32'h20);
    drive(1, 0, 0, '0, 0, '0, 0, 1);     cyc(); check("ret_as_step", iaddrout, 32'h24);
    check("off_miss", W'(ret_miss), 32'h0);
    check("off_empty", W'(ras_empty), 32'h1);
`endif

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [W-1:0] v;
      v = W'($urandom_range(0, 255)) << 2;
      if ($urandom_range(0, 1) == 1) v = -v;
      if ($urandom_range(0, 15) == 0) v = $urandom;
      drive($urandom_range(0, 63) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
            $urandom, $urandom_range(0, 3) == 0, v, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
